dlsc_pcie_s6_inbound_cpl_tlp: RTL and testbench
===============================================

Name: dlsc_pcie_s6_inbound_cpl_tlp

Overview:
Completion TLP generator directly downstream of the inbound read engine. It consumes the completion header stream (cpl_h_*) and the completion data stream (cpl_d_*). It merges each header with the requester context (requester ID, tag, TC, attr) queued by the dispatcher, and emits 3DW Cpl/CplD TLPs as a 32-bit word stream toward the Spartan-6 TX arbiter.

Parameters:
CTXA, 4, log2 depth of the internal requester-context FIFO (16 entries).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
completer_id  in  16  bus/dev/func from config space, sampled when the header is latched
ctx_ready  out  1  context FIFO not full
ctx_valid  in  1  push request context (one per non-posted read)
ctx_req_id  in  16  requester ID
ctx_tag  in  8  tag
ctx_tc  in  3  traffic class
ctx_attr  in  2  attributes (relaxed ordering, no-snoop)
cpl_h_ready  out  1  header pop
cpl_h_valid  in  1  header available
cpl_h_addr  in  7  lower address
cpl_h_len  in  10  payload length in DW; 0 encodes 1024
cpl_h_bytes  in  12  remaining byte count; 0 encodes 4096
cpl_h_last  in  1  final completion of the request
cpl_h_resp  in  2  AXI response: 00 OKAY, 10 SLVERR, 11 DECERR
cpl_d_ready  out  1  data pop
cpl_d_valid  in  1  data available
cpl_d_data  in  32  payload DW
cpl_d_last  in  1  last DW of this completion
tlp_ready  in  1  downstream accept
tlp_valid  out  1  TLP word valid
tlp_data  out  32  TLP word
tlp_last  out  1  last word of TLP
err_framing  out  1  sticky: cpl_d_last disagreed with internal DW count

Behaviour:
- Async reset (rst_n low) clears the context FIFO, returns the FSM to IDLE, and clears the kill flag and err_framing. Outputs during reset: tlp_valid=0, tlp_last=0, cpl_h_ready=0, cpl_d_ready=0, ctx_ready=1. Reset mid-TLP abandons the packet with no further words.
- Context FIFO: 2^CTXA entries, first-word-fall-through. ctx_ready=!full. A push while full is dropped.
- FSM states: IDLE, H0, H1, H2, DATA, DRAIN.
- IDLE: when cpl_h_valid && ctx FIFO non-empty, assert cpl_h_ready for one cycle and latch header, context head and completer_id. Next state:
  - H0 if kill=0 and resp=OKAY;
  - H0 with status set if kill=0 and resp!=OKAY;
  - DRAIN if kill=1.
- Latency: first word valid the cycle after the header pop.
- Status mapping: OKAY→SC 000; SLVERR→CA 100; DECERR→UR 001.
- Error completion: a non-OKAY resp produces a Cpl (no data) with length=0 and byte_count=cpl_h_bytes, then DRAIN. It also sets kill unless cpl_h_last=1.
- Header words, each held until tlp_ready:
  - H0: {1'b0, fmt, type=01010, 1'b0, tc, 4'b0, TD=0, EP=0, attr, 2'b0, length}. fmt=10 (CplD) or 00 (Cpl).
  - H1: {completer_id, status, BCM=0, byte_count}.
  - H2: {req_id, tag, 1'b0, lower_addr}.
- tlp_last=1 only on H2 of a Cpl.
- After H2: a CplD goes to DATA; an error Cpl goes to DRAIN.
- DATA: combinational pass-through. tlp_valid=cpl_d_valid, cpl_d_ready=tlp_ready, tlp_data=cpl_d_data.
  - 10-bit count starts at 1; tlp_last=(count==len), with len 0 treated as 1024.
  - On the final transfer, return to IDLE.
- DRAIN: cpl_d_ready=1, tlp_valid=0; discard len DW, then go to IDLE.
- Framing check: in DATA and DRAIN, cpl_d_last must equal (count==len) on every transfer. A mismatch sets err_framing; counting continues by len regardless.
- Request completion: when the latched cpl_h_last=1, the context head is popped and kill is cleared as the FSM returns to IDLE. Context pop and push may occur in the same cycle; FIFO occupancy is then unchanged.
- No new header is accepted until the FSM returns to IDLE. There is no back-to-back overlap: one idle cycle between TLPs.

Decomposition:
- Shared package dlsc_pcie_s6_pkg: TLP fmt/type constants (CPL=0x0A, CPLD=0x4A byte0), completion status codes (SC/UR/CA), AXI resp codes.
- The requester-context queue is an instance of the existing dlsc_rvh_fifo (DATA=29, DEPTH=2^CTXA).
- The FSM and header muxing stay in this module.

Test Plan:
1. 1DW OKAY read, ctx {req_id=0x0100, tag=0x05}, completer_id=0x0200, addr=0x04, len=1, bytes=4 → words 0x4A000001, 0x02000004, 0x01000504, data; tlp_last on data word.
2. len=0 (1024 DW) with tlp_ready toggled every other cycle → 1024 data words, no drops/dups, tlp_last only on word 1027.
3. Two completions (len=16, last=0; len=8, last=1) for one request → both use the same tag, context popped only after the second.
4. DECERR on first of two completions (len=4) → Cpl 0x0A000000 with status UR in H1, 4 data words drained, second completion fully drained with no TLP output.
5. cpl_d_last asserted on word 3 of len=4 → err_framing=1 (sticky), 4 words still forwarded.
6. rst_n asserted mid-DATA, then released → tlp_valid=0 immediately, ctx_ready=1, next header pops cleanly.

Source files
------------

// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared PCIe completion constants: TLP byte-0 codes, completion status codes,
// AXI response codes and the requester-context record queued per read.
package dlsc_pcie_s6_pkg;

  localparam logic [7:0] TLP_CPL  = 8'h0A;
  localparam logic [7:0] TLP_CPLD = 8'h4A;

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001,
    CPL_CA = 3'b100
  } cpl_status_t;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H0,
    ST_H1,
    ST_H2,
    ST_DATA,
    ST_DRAIN
  } cpl_state_t;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
  } cpl_ctx_t;

  localparam int CTX_W = $bits(cpl_ctx_t);

  // Anything that is neither OKAY nor DECERR is reported as Completer Abort.
  function automatic cpl_status_t resp_to_status(input logic [1:0] resp);
    case (resp)
      AXI_OKAY:   return CPL_SC;
      AXI_DECERR: return CPL_UR;
      default:    return CPL_CA;
    endcase
  endfunction

endpackage

// File: rtl/dlsc_rvh_fifo.sv
// First-word-fall-through ready/valid FIFO; DEPTH must be a power of two.
module dlsc_rvh_fifo #(
  parameter int DATA  = 29,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            in_ready,
  input  logic            in_valid,
  input  logic [DATA-1:0] in_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DATA-1:0] out_data
);

  localparam int ADDR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);

  logic [DATA-1:0] mem [DEPTH];
  logic [ADDR-1:0] wr_ptr;
  logic [ADDR-1:0] rd_ptr;
  logic [ADDR:0]   cnt;
  logic            push;
  logic            pop;

  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/dlsc_pcie_s6_inbound_cpl_tlp.sv
// Builds 3DW Cpl/CplD TLPs from completion headers, payload and queued
// requester context, streaming them as 32-bit words toward the TX arbiter.
module dlsc_pcie_s6_inbound_cpl_tlp
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int CTXA = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] completer_id,
  output logic        ctx_ready,
  input  logic        ctx_valid,
  input  logic [15:0] ctx_req_id,
  input  logic [7:0]  ctx_tag,
  input  logic [2:0]  ctx_tc,
  input  logic [1:0]  ctx_attr,
  output logic        cpl_h_ready,
  input  logic        cpl_h_valid,
  input  logic [6:0]  cpl_h_addr,
  input  logic [9:0]  cpl_h_len,
  input  logic [11:0] cpl_h_bytes,
  input  logic        cpl_h_last,
  input  logic [1:0]  cpl_h_resp,
  output logic        cpl_d_ready,
  input  logic        cpl_d_valid,
  input  logic [31:0] cpl_d_data,
  input  logic        cpl_d_last,
  input  logic        tlp_ready,
  output logic        tlp_valid,
  output logic [31:0] tlp_data,
  output logic        tlp_last,
  output logic        err_framing
);

  cpl_state_t  state;
  cpl_state_t  state_nxt;
  cpl_ctx_t    ctx_in;
  cpl_ctx_t    ctx_head;
  logic        ctx_head_valid;
  logic        ctx_pop;

  cpl_ctx_t    ctx_lat;
  logic [15:0] cid_lat;
  logic [6:0]  addr_lat;
  logic [9:0]  len_lat;
  logic [11:0] bytes_lat;
  logic        last_lat;
  logic        err_lat;
  cpl_status_t status_lat;

  logic [9:0]  cnt;
  logic        kill;
  logic        hdr_pop;
  logic        d_xfer;
  logic        cnt_end;
  logic        done;

  assign ctx_in = {ctx_req_id, ctx_tag, ctx_tc, ctx_attr};

  dlsc_rvh_fifo #(
    .DATA  (CTX_W),
    .DEPTH (1 << CTXA)
  ) u_ctx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (ctx_ready),
    .in_valid  (ctx_valid),
    .in_data   (ctx_in),
    .out_ready (ctx_pop),
    .out_valid (ctx_head_valid),
    .out_data  (ctx_head)
  );

  assign hdr_pop = (state == ST_IDLE) && cpl_h_valid && ctx_head_valid;
  // The 10-bit count wraps to 0 on the 1024th DW, matching the len==0 encoding.
  assign cnt_end = (cnt == len_lat);
  assign d_xfer  = cpl_d_valid && cpl_d_ready;
  assign done    = d_xfer && cnt_end;
  assign ctx_pop = done && last_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (hdr_pop)   state_nxt = kill ? ST_DRAIN : ST_H0;
      ST_H0:    if (tlp_ready) state_nxt = ST_H1;
      ST_H1:    if (tlp_ready) state_nxt = ST_H2;
      ST_H2:    if (tlp_ready) state_nxt = err_lat ? ST_DRAIN : ST_DATA;
      ST_DATA:  if (done)      state_nxt = ST_IDLE;
      ST_DRAIN: if (done)      state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cpl_h_ready = 1'b0;
    cpl_d_ready = 1'b0;
    tlp_valid   = 1'b0;
    tlp_last    = 1'b0;
    tlp_data    = '0;
    case (state)
      ST_IDLE: cpl_h_ready = hdr_pop;
      ST_H0: begin
        tlp_valid = 1'b1;
        tlp_data  = {err_lat ? TLP_CPL : TLP_CPLD, 1'b0, ctx_lat.tc, 4'b0,
                     2'b00, ctx_lat.attr, 2'b00, err_lat ? 10'd0 : len_lat};
      end
      ST_H1: begin
        tlp_valid = 1'b1;
        tlp_data  = {cid_lat, status_lat, 1'b0, bytes_lat};
      end
      ST_H2: begin
        tlp_valid = 1'b1;
        tlp_data  = {ctx_lat.req_id, ctx_lat.tag, 1'b0, addr_lat};
        tlp_last  = err_lat;
      end
      ST_DATA: begin
        tlp_valid   = cpl_d_valid;
        cpl_d_ready = tlp_ready;
        tlp_data    = cpl_d_data;
        tlp_last    = cnt_end;
      end
      ST_DRAIN: cpl_d_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 10'd1;
      kill        <= 1'b0;
      err_framing <= 1'b0;
    end else begin
      if (hdr_pop)     cnt <= 10'd1;
      else if (d_xfer) cnt <= cnt + 10'd1;
      // An errored partial completion poisons the rest of its request.
      if (ctx_pop)
        kill <= 1'b0;
      else if (hdr_pop && !kill && (cpl_h_resp != AXI_OKAY) && !cpl_h_last)
        kill <= 1'b1;
      if (d_xfer && (cpl_d_last != cnt_end)) err_framing <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_pop) begin
      ctx_lat    <= ctx_head;
      cid_lat    <= completer_id;
      addr_lat   <= cpl_h_addr;
      len_lat    <= cpl_h_len;
      bytes_lat  <= cpl_h_bytes;
      last_lat   <= cpl_h_last;
      err_lat    <= (cpl_h_resp != AXI_OKAY);
      status_lat <= resp_to_status(cpl_h_resp);
    end
  end

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_cpl_tlp.sv
// Scoreboard bench: stimulus queues feed randomized ready/valid drivers while a
// reference model predicts the TLP word stream that the monitor compares.
module tb_dlsc_pcie_s6_inbound_cpl_tlp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] completer_id;
  logic        ctx_ready, ctx_valid;
  logic [15:0] ctx_req_id;
  logic [7:0]  ctx_tag;
  logic [2:0]  ctx_tc;
  logic [1:0]  ctx_attr;
  logic        cpl_h_ready, cpl_h_valid;
  logic [6:0]  cpl_h_addr;
  logic [9:0]  cpl_h_len;
  logic [11:0] cpl_h_bytes;
  logic        cpl_h_last;
  logic [1:0]  cpl_h_resp;
  logic        cpl_d_ready, cpl_d_valid;
  logic [31:0] cpl_d_data;
  logic        cpl_d_last;
  logic        tlp_ready, tlp_valid;
  logic [31:0] tlp_data;
  logic        tlp_last;
  logic        err_framing;

  always #5 clk = ~clk;

  dlsc_pcie_s6_inbound_cpl_tlp #(.CTXA(4)) dut (
    .clk(clk), .rst_n(rst_n), .completer_id(completer_id),
    .ctx_ready(ctx_ready), .ctx_valid(ctx_valid), .ctx_req_id(ctx_req_id),
    .ctx_tag(ctx_tag), .ctx_tc(ctx_tc), .ctx_attr(ctx_attr),
    .cpl_h_ready(cpl_h_ready), .cpl_h_valid(cpl_h_valid), .cpl_h_addr(cpl_h_addr),
    .cpl_h_len(cpl_h_len), .cpl_h_bytes(cpl_h_bytes), .cpl_h_last(cpl_h_last),
    .cpl_h_resp(cpl_h_resp),
    .cpl_d_ready(cpl_d_ready), .cpl_d_valid(cpl_d_valid), .cpl_d_data(cpl_d_data),
    .cpl_d_last(cpl_d_last),
    .tlp_ready(tlp_ready), .tlp_valid(tlp_valid), .tlp_data(tlp_data),
    .tlp_last(tlp_last), .err_framing(err_framing)
  );

  typedef struct packed {
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
  } tctx_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [9:0]  len;
    logic [11:0] bytes;
    logic        last;
    logic [1:0]  resp;
  } thdr_t;

  tctx_t       ctx_q[$];
  thdr_t       hdr_q[$];
  logic [32:0] dat_q[$];
  logic [32:0] exp_q[$];
  tctx_t       m_ctx[$];
  bit          m_kill = 1'b0;

  int checks = 0;
  int failures = 0;
  int nwords = 0;
  bit en_drv = 1'b1;
  bit hdr_en = 1'b1;
  bit ctx_force = 1'b0;
  int rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic issue_ctx(input tctx_t c, input bit dropped);
    ctx_q.push_back(c);
    if (!dropped) m_ctx.push_back(c);
  endtask

  // Reference: one completion per call; the requester record is the oldest
  // outstanding request, retired when its last completion has been consumed.
  task automatic issue_cpl(input logic [6:0] addr, input logic [9:0] len,
                           input logic [11:0] bytes, input bit last,
                           input logic [1:0] resp, input int last_at);
    tctx_t       c;
    int          nw;
    int          la;
    int          st;
    bit          ok;
    bit          emit;
    logic [31:0] d;
    c    = m_ctx[0];
    nw   = (len == 10'd0) ? 1024 : int'(len);
    la   = (last_at < 0) ? nw - 1 : last_at;
    ok   = (resp == 2'b00);
    emit = !m_kill;
    st   = (resp == 2'b11) ? 1 : (resp == 2'b10) ? 4 : (resp == 2'b01) ? 4 : 0;
    hdr_q.push_back({addr, len, bytes, last, resp});
    if (emit) begin
      exp_q.push_back({1'b0, (ok ? 32'h4A000000 : 32'h0A000000) | (32'(c.tc) << 20) |
                             (32'(c.attr) << 12) | (ok ? 32'(len) : 32'd0)});
      exp_q.push_back({1'b0, (32'(completer_id) << 16) | (32'(st) << 13) | 32'(bytes)});
      exp_q.push_back({!ok, (32'(c.rid) << 16) | (32'(c.tag) << 8) | 32'(addr)});
    end
    for (int i = 0; i < nw; i++) begin
      d = $urandom;
      dat_q.push_back({(i == la), d});
      if (emit && ok) exp_q.push_back({(i == nw - 1), d});
    end
    if (emit && !ok && !last) m_kill = 1'b1;
    if (last) begin
      void'(m_ctx.pop_front());
      m_kill = 1'b0;
    end
  endtask

  task automatic rand_ctx(output tctx_t c);
    logic [31:0] rv;
    rv = $urandom;
    c  = rv[28:0];
  endtask

  task automatic rand_req(input int ncpl, input bit allow_err);
    tctx_t       c;
    logic [31:0] rv;
    logic [1:0]  rs;
    int          p;
    rand_ctx(c);
    issue_ctx(c, 1'b0);
    for (int k = 0; k < ncpl; k++) begin
      rv = $urandom;
      p  = allow_err ? $urandom_range(9) : 9;
      rs = (p == 0) ? 2'b11 : (p == 1) ? 2'b10 : 2'b00;
      issue_cpl(rv[6:0], 10'($urandom_range(1, 16)), rv[18:7], (k == ncpl - 1), rs, -1);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() + ctx_q.size() + hdr_q.size() + dat_q.size()) != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_outstanding"}, 64'(exp_q.size() + ctx_q.size() + hdr_q.size() + dat_q.size()), 64'd0);
    repeat (4) @(posedge clk);
  endtask

  initial begin : ctx_drv
    bit fire;
    ctx_valid = 1'b0;
    {ctx_req_id, ctx_tag, ctx_tc, ctx_attr} = '0;
    forever begin
      @(negedge clk);
      fire = ctx_valid && (ctx_ready || ctx_force);
      @(posedge clk); #1;
      if (fire) begin
        void'(ctx_q.pop_front());
        ctx_valid = 1'b0;
      end
      if (!en_drv) ctx_valid = 1'b0;
      else if (!ctx_valid && ctx_q.size() > 0 && $urandom_range(3) != 0) begin
        ctx_valid = 1'b1;
        {ctx_req_id, ctx_tag, ctx_tc, ctx_attr} = ctx_q[0];
      end
    end
  end

  initial begin : hdr_drv
    bit fire;
    cpl_h_valid = 1'b0;
    {cpl_h_addr, cpl_h_len, cpl_h_bytes, cpl_h_last, cpl_h_resp} = '0;
    forever begin
      @(negedge clk);
      fire = cpl_h_valid && cpl_h_ready;
      @(posedge clk); #1;
      if (fire) begin
        void'(hdr_q.pop_front());
        cpl_h_valid = 1'b0;
      end
      if (!en_drv || !hdr_en) cpl_h_valid = 1'b0;
      else if (!cpl_h_valid && hdr_q.size() > 0 && $urandom_range(3) != 0) begin
        cpl_h_valid = 1'b1;
        {cpl_h_addr, cpl_h_len, cpl_h_bytes, cpl_h_last, cpl_h_resp} = hdr_q[0];
      end
    end
  end

  initial begin : dat_drv
    bit fire;
    cpl_d_valid = 1'b0;
    {cpl_d_last, cpl_d_data} = '0;
    forever begin
      @(negedge clk);
      fire = cpl_d_valid && cpl_d_ready;
      @(posedge clk); #1;
      if (fire) begin
        void'(dat_q.pop_front());
        cpl_d_valid = 1'b0;
      end
      if (!en_drv) cpl_d_valid = 1'b0;
      else if (!cpl_d_valid && dat_q.size() > 0 && $urandom_range(7) != 0) begin
        cpl_d_valid = 1'b1;
        {cpl_d_last, cpl_d_data} = dat_q[0];
      end
    end
  end

  initial begin : rdy_drv
    bit ph;
    ph = 1'b0;
    tlp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      ph = !ph;
      case (rdy_mode)
        0:       tlp_ready = 1'b1;
        1:       tlp_ready = ($urandom_range(3) != 0);
        default: tlp_ready = ph;
      endcase
    end
  end

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tlp_valid && tlp_ready) begin
        nwords++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h last=%0d required=none", tlp_data, tlp_last);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("word%0d", nwords), {31'b0, tlp_last, tlp_data}, {31'b0, e});
        end
      end
    end
  end

  initial begin : main
    tctx_t c;
    int    base;
    int    n;
    logic [31:0] rv;
    rst_n = 1'b0;
    completer_id = 16'h0200;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tlp_valid", tlp_valid, 0);
    chk("rst_tlp_last", tlp_last, 0);
    chk("rst_cpl_h_ready", cpl_h_ready, 0);
    chk("rst_cpl_d_ready", cpl_d_ready, 0);
    chk("rst_ctx_ready", ctx_ready, 1);
    chk("rst_err_framing", err_framing, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1DW OKAY read with fixed expected words.
    ctx_q.push_back({16'h0100, 8'h05, 3'd0, 2'd0});
    hdr_q.push_back({7'h04, 10'd1, 12'd4, 1'b1, 2'b00});
    dat_q.push_back({1'b1, 32'hCAFEF00D});
    exp_q.push_back({1'b0, 32'h4A000001});
    exp_q.push_back({1'b0, 32'h02000004});
    exp_q.push_back({1'b0, 32'h01000504});
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    wait_idle("t1");

    // 1024-DW completion under alternating backpressure.
    rdy_mode = 2;
    rand_ctx(c);
    issue_ctx(c, 1'b0);
    issue_cpl(7'h10, 10'd0, 12'd0, 1'b1, 2'b00, -1);
    wait_idle("t2");
    rdy_mode = 1;

    // Split request: both completions carry the same tag; the next request must not.
    rand_ctx(c);
    issue_ctx(c, 1'b0);
    issue_cpl(7'h00, 10'd16, 12'd96, 1'b0, 2'b00, -1);
    issue_cpl(7'h40, 10'd8, 12'd32, 1'b1, 2'b00, -1);
    rand_req(1, 1'b0);
    wait_idle("t3");

    // DECERR on first completion kills the second.
    issue_ctx({16'h1234, 8'h77, 3'd0, 2'd0}, 1'b0);
    issue_cpl(7'h08, 10'd4, 12'd32, 1'b0, 2'b11, -1);
    issue_cpl(7'h18, 10'd4, 12'd16, 1'b1, 2'b00, -1);
    rand_req(1, 1'b0);
    wait_idle("t4");
    chk("err_framing_clean", err_framing, 0);

    // Early cpl_d_last: payload still forwarded by length, error latched.
    rand_ctx(c);
    issue_ctx(c, 1'b0);
    issue_cpl(7'h20, 10'd4, 12'd16, 1'b1, 2'b00, 2);
    wait_idle("t5");
    chk("err_framing_set", err_framing, 1);
    rand_req(1, 1'b0);
    wait_idle("t5b");
    chk("err_framing_sticky", err_framing, 1);

    for (int r = 0; r < 25; r++) rand_req($urandom_range(1, 3), 1'b1);
    wait_idle("rand");

    // Fill the context FIFO, then force a push that must be dropped.
    hdr_en = 1'b0;
    for (int r = 0; r < 16; r++) begin
      rand_ctx(c);
      issue_ctx(c, 1'b0);
    end
    n = 0;
    while (ctx_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("ctx_full_ready", ctx_ready, 0);
    ctx_force = 1'b1;
    issue_ctx({16'hDEAD, 8'hEE, 3'd7, 2'd3}, 1'b1);
    n = 0;
    while (ctx_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("ctx_forced_consumed", 64'(ctx_q.size()), 0);
    ctx_force = 1'b0;
    @(posedge clk); #1;
    chk("ctx_full_hold", ctx_ready, 0);
    hdr_en = 1'b1;
    for (int r = 0; r < 16; r++) begin
      rv = $urandom;
      issue_cpl(rv[6:0], 10'($urandom_range(1, 4)), rv[18:7], 1'b1, 2'b00, -1);
    end
    rand_req(1, 1'b0);
    wait_idle("full");

    // Reset in the middle of a payload.
    rdy_mode = 0;
    rand_ctx(c);
    issue_ctx(c, 1'b0);
    issue_cpl(7'h00, 10'd32, 12'd128, 1'b1, 2'b00, -1);
    base = nwords;
    n = 0;
    while (nwords < base + 6 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("t6_reached_data", 64'(nwords >= base + 6), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_tlp_valid", tlp_valid, 0);
    chk("t6_tlp_last", tlp_last, 0);
    chk("t6_cpl_d_ready", cpl_d_ready, 0);
    chk("t6_cpl_h_ready", cpl_h_ready, 0);
    chk("t6_ctx_ready", ctx_ready, 1);
    chk("t6_err_framing", err_framing, 0);
    en_drv = 1'b0;
    repeat (3) @(posedge clk);
    ctx_q.delete();
    hdr_q.delete();
    dat_q.delete();
    exp_q.delete();
    m_ctx.delete();
    m_kill = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    en_drv = 1'b1;
    rdy_mode = 1;
    rand_req(2, 1'b0);
    wait_idle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
